crypto_key_ctrl: RTL

- Key controller for the crypto XOR datapath; owns the active 32-bit key the datapath replicates across the data word.
- Changes the key only between packets, so no packet is ever processed with two keys.
- Sources of a new key: a CPU write (staged in a shadow register) or automatic rotation after a programmable number of packets.
- Monitors the datapath input handshake and inserts a one-cycle input stall to force a key-change window under back-to-back traffic.

---
 rtl/crypto_key_ctrl_if.sv | 23 ++
 rtl/crypto_key_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/crypto_key_ctrl_if.sv
// Snooped datapath input handshake plus the stall gate fed back to the
// upstream tready. The master side is the datapath/integration wrapper,
// the slave side is the key controller.
interface crypto_key_ctrl_if;
    logic mon_tvalid;
    logic mon_tready;
    logic mon_tlast;
    logic stall;

    modport master (
        output mon_tvalid,
        output mon_tready,
        output mon_tlast,
        input  stall
    );

    modport slave (
        input  mon_tvalid,
        input  mon_tready,
        input  mon_tlast,
        output stall
    );
endinterface

// File: rtl/crypto_key_ctrl.sv
// Key controller for the crypto XOR datapath.
// Owns the active key and swaps it only on packet boundaries. A new key
// comes either from a CPU write (held in a shadow register) or from an
// automatic rotation after a programmable number of packets. When a change
// is pending at a packet boundary the controller raises stall for exactly
// one cycle; that cycle is the commit window, so back-to-back traffic can
// never carry a packet across two keys.
module crypto_key_ctrl #(
    parameter int unsigned          KEY_WIDTH   = 32,
    parameter int unsigned          EPOCH_WIDTH = 8,
    parameter int unsigned          CNT_WIDTH   = 32,
    parameter logic [KEY_WIDTH-1:0] RESET_KEY   = 32'hFFFF_FFFF,
    parameter logic [KEY_WIDTH-1:0] ROT_XOR     = 32'h0000_00A5
) (
    input  logic                   axis_aclk,
    input  logic                   axis_reset,
    crypto_key_ctrl_if.slave       mon,
    input  logic                   key_wr_en,
    input  logic [KEY_WIDTH-1:0]   key_wr_data,
    input  logic                   rotate_en,
    input  logic [15:0]            rotate_pkts,
    output logic [KEY_WIDTH-1:0]   key_out,
    output logic [EPOCH_WIDTH-1:0] key_epoch,
    output logic                   key_update,
    output logic                   pending,
    output logic [CNT_WIDTH-1:0]   pkt_count
);

    // Packet framing: IDLE means the next accepted beat opens a packet.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } state_t;

    localparam logic [15:0] ROT_CNT_MAX = 16'hFFFF;

    // Rotate left by one bit.
    function automatic logic [KEY_WIDTH-1:0] rotl1(input logic [KEY_WIDTH-1:0] k);
        return {k[KEY_WIDTH-2:0], k[KEY_WIDTH-1]};
    endfunction

    // Key derived from the current one on an automatic rotation.
    function automatic logic [KEY_WIDTH-1:0] rotated_key(input logic [KEY_WIDTH-1:0] k);
        return rotl1(k) ^ ROT_XOR;
    endfunction

    state_t                 state_r;
    logic [KEY_WIDTH-1:0]   key_r;
    logic [KEY_WIDTH-1:0]   shadow_r;
    logic [EPOCH_WIDTH-1:0] epoch_r;
    logic                   update_r;
    logic                   cpu_pend_r;
    logic                   rot_pend_r;
    logic [CNT_WIDTH-1:0]   pkt_cnt_r;
    logic [15:0]            rot_cnt_r;

    logic                   beat_s;
    logic                   tlast_beat_s;
    logic                   pending_s;
    logic                   commit_s;
    logic                   rot_due_s;

    // Handshake decode, pending summary and the commit/stall window.
    always_comb begin
        beat_s       = 1'b0;
        tlast_beat_s = 1'b0;
        pending_s    = 1'b0;
        commit_s     = 1'b0;
        rot_due_s    = 1'b0;

        beat_s       = mon.mon_tvalid & mon.mon_tready;
        tlast_beat_s = beat_s & mon.mon_tlast;
        pending_s    = cpu_pend_r | rot_pend_r;
        // tready is gated by stall downstream, so no beat lands in this cycle.
        commit_s     = (state_r == ST_IDLE) & pending_s;
        rot_due_s    = rotate_en & (rotate_pkts != 16'h0000) & (rot_cnt_r >= rotate_pkts);
    end

    // Packet framing FSM tracking whether we sit on a packet boundary.
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (beat_s && !mon.mon_tlast) begin
                        state_r <= ST_IN_PKT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_IN_PKT: begin
                    if (tlast_beat_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_IN_PKT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Active key, epoch and update pulse; changes only at the commit edge.
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            key_r    <= RESET_KEY;
            epoch_r  <= {EPOCH_WIDTH{1'b0}};
            update_r <= 1'b0;
        end else if (commit_s) begin
            // CPU key wins over a rotation requested at the same boundary.
            if (cpu_pend_r) begin
                key_r <= shadow_r;
            end else begin
                key_r <= rotated_key(key_r);
            end
            epoch_r  <= epoch_r + EPOCH_WIDTH'(1);
            update_r <= 1'b1;
        end else begin
            update_r <= 1'b0;
        end
    end

    // Shadow key and the two change requests.
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            shadow_r   <= {KEY_WIDTH{1'b0}};
            cpu_pend_r <= 1'b0;
            rot_pend_r <= 1'b0;
        end else begin
            // A write in the commit cycle stays pending for the next boundary;
            // the commit itself still sees the previous shadow value.
            if (key_wr_en) begin
                shadow_r   <= key_wr_data;
                cpu_pend_r <= 1'b1;
            end else if (commit_s) begin
                cpu_pend_r <= 1'b0;
            end else begin
                cpu_pend_r <= cpu_pend_r;
            end
            // Re-evaluated every cycle so dropping rotate_en withdraws it.
            if (commit_s) begin
                rot_pend_r <= 1'b0;
            end else begin
                rot_pend_r <= rot_due_s;
            end
        end
    end

    // Completed-packet counters: total (wrapping) and since-last-key (saturating).
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            pkt_cnt_r <= {CNT_WIDTH{1'b0}};
            rot_cnt_r <= 16'h0000;
        end else begin
            if (tlast_beat_s) begin
                pkt_cnt_r <= pkt_cnt_r + CNT_WIDTH'(1);
            end else begin
                pkt_cnt_r <= pkt_cnt_r;
            end
            if (commit_s) begin
                rot_cnt_r <= 16'h0000;
            end else if (tlast_beat_s && (rot_cnt_r != ROT_CNT_MAX)) begin
                rot_cnt_r <= rot_cnt_r + 16'h0001;
            end else begin
                rot_cnt_r <= rot_cnt_r;
            end
        end
    end

    assign mon.stall  = commit_s;
    assign key_out    = key_r;
    assign key_epoch  = epoch_r;
    assign key_update = update_r;
    assign pending    = pending_s;
    assign pkt_count  = pkt_cnt_r;

endmodule
